// File: rtl/uart_receiver.sv
// UART 8N1 receiver (LSB first): ready/valid byte port, per-byte framing error, overrun pulse.
// Build option UART_RX_MAJORITY_VOTE_EN: each bit sample is a 3-cycle majority vote of rx_s.
module uart_receiver #(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       frame_error,
    output logic       overrun
);
    localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int unsigned CNT_W            = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic             rx_meta;
    logic             rx_s;
    logic             rx_prev;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             sample_c;

    // Two-flop synchronizer plus one-cycle history for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= serial_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic rx_prev2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_prev2 <= 1'b1;
        else     rx_prev2 <= rx_prev;
    end

    assign sample_c = (rx_s & rx_prev) | (rx_s & rx_prev2) | (rx_prev & rx_prev2);
`else
    assign sample_c = rx_s;
`endif

    // Frame FSM, bit timing and output register; a finished byte may only replace an empty or consumed slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            clk_cnt        <= '0;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            frame_error    <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            overrun <= 1'b0;
            clk_cnt <= clk_cnt + 1'b1;
            if (data_out_valid && data_out_ready)
                data_out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (rx_prev && !rx_s)
                        state <= START;
                end
                START: begin
                    if (clk_cnt == SAMPLE_LAST) begin
                        if (sample_c) begin
                            state <= IDLE;
                        end else begin
                            clk_cnt <= '0;
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (clk_cnt == SYMBOL_LAST) begin
                        clk_cnt   <= '0;
                        shift_reg <= {sample_c, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= STOP;
                    end
                end
                STOP: begin
                    if (clk_cnt == SYMBOL_LAST) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        if (!data_out_valid || data_out_ready) begin
                            data_out       <= shift_reg;
                            frame_error    <= !sample_c;
                            data_out_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
